// File: rtl/aes128_encrypt_ctrl.sv
// Iterative AES-128 encryption controller: one cipher round per clock with an on-the-fly
// round key. mixcolumns is the combinational column-mixing datapath it drives each round.

module mixcolumns (
   input  logic         clk,
   input  logic [127:0] i_state,
   output logic [127:0] o_state
);
   // The clock input exists for interface compatibility; this datapath is purely combinational.
   logic w_unused_clk;
   assign w_unused_clk = clk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Row 0 is the most significant byte of each 32-bit word.
   function automatic logic [31:0] mix_word(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      a0 = w[31:24];
      a1 = w[23:16];
      a2 = w[15:8];
      a3 = w[7:0];
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   for (genvar c = 0; c < 4; c++) begin : g_word
      assign o_state[32*c+31 -: 32] = mix_word(i_state[32*c+31 -: 32]);
   end
endmodule

module aes128_encrypt_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic         busy
);
   typedef enum logic [1:0] {StIdle, StRound, StFinal, StHold} state_e;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   // Entry x sits at bit offset 8*(255-x), which is {~x, 3'b000}.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   state_e        r_state, w_state_nxt;
   logic [127:0]  r_st, w_st_nxt;
   logic [127:0]  r_rk, w_rk_nxt;
   logic [3:0]    r_rnd, w_rnd_nxt;

   logic [127:0]  w_sb, w_sr, w_mc_in, w_mc_out, w_mc;
   logic [31:0]   w_rot, w_sub, w_t;
   logic [127:0]  w_nk;
   logic [7:0]    w_rcon;

   // State bytes are FIPS-ordered: byte i = row (i % 4), column (i / 4), at bits [127-8i -: 8].
   for (genvar g = 0; g < 16; g++) begin : g_sb
      assign w_sb[127-8*g -: 8] = sbox(r_st[127-8*g -: 8]);
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign w_sr[127-8*(r+4*c) -: 8] = w_sb[127-8*(r+4*((c+r)%4)) -: 8];
      end
      assign w_mc_in[32*c+31 -: 32] = w_sr[127-32*c -: 32];
      assign w_mc[127-32*c -: 32]   = w_mc_out[32*c+31 -: 32];
   end

   mixcolumns u_mixcolumns (
      .clk     (clk),
      .i_state (w_mc_in),
      .o_state (w_mc_out)
   );

   always_comb begin
      w_rcon = 8'h00;
      case (r_rnd)
         4'd1:    w_rcon = 8'h01;
         4'd2:    w_rcon = 8'h02;
         4'd3:    w_rcon = 8'h04;
         4'd4:    w_rcon = 8'h08;
         4'd5:    w_rcon = 8'h10;
         4'd6:    w_rcon = 8'h20;
         4'd7:    w_rcon = 8'h40;
         4'd8:    w_rcon = 8'h80;
         4'd9:    w_rcon = 8'h1b;
         4'd10:   w_rcon = 8'h36;
         default: w_rcon = 8'h00;
      endcase
   end

   assign w_rot = {r_rk[23:0], r_rk[31:24]};
   assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
   assign w_t   = w_sub ^ {w_rcon, 24'h000000};
   assign w_nk[127:96] = r_rk[127:96] ^ w_t;
   assign w_nk[95:64]  = r_rk[95:64]  ^ w_nk[127:96];
   assign w_nk[63:32]  = r_rk[63:32]  ^ w_nk[95:64];
   assign w_nk[31:0]   = r_rk[31:0]   ^ w_nk[63:32];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_st    <= '0;
         r_rk    <= '0;
         r_rnd   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_st    <= w_st_nxt;
         r_rk    <= w_rk_nxt;
         r_rnd   <= w_rnd_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_st_nxt    = r_st;
      w_rk_nxt    = r_rk;
      w_rnd_nxt   = r_rnd;
      case (r_state)
         StIdle: begin
            if (in_valid) begin
               w_st_nxt    = plaintext ^ key;
               w_rk_nxt    = key;
               w_rnd_nxt   = 4'd1;
               w_state_nxt = StRound;
            end
         end
         StRound: begin
            w_st_nxt  = w_mc ^ w_nk;
            w_rk_nxt  = w_nk;
            w_rnd_nxt = r_rnd + 4'd1;
            if (r_rnd == 4'd9) w_state_nxt = StFinal;
         end
         StFinal: begin
            w_st_nxt    = w_sr ^ w_nk;
            w_state_nxt = StHold;
         end
         StHold: begin
            if (out_ready) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign in_ready   = (r_state == StIdle);
   assign out_valid  = (r_state == StHold);
   assign busy       = (r_state == StRound) || (r_state == StFinal);
   assign ciphertext = r_st;
endmodule

// File: tb/tb_aes128_encrypt_ctrl.sv
// Scoreboard bench for aes128_encrypt_ctrl: accepted blocks are modelled with a byte-level AES
// reference whose S-box is derived from GF(2^8) inversion; a monitor checks each output.

module tb_aes128_encrypt_ctrl;
   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready;
   logic [127:0] plaintext, key;
   logic         in_ready, out_valid, busy;
   logic [127:0] ciphertext;

   aes128_encrypt_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

   typedef struct {
      logic [127:0] ct;
      logic [127:0] kat;
      bit           has_kat;
      int           acc;
   } exp_t;

   exp_t         exp_q[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   bit           rand_or = 1'b0;
   logic [127:0] kat;
   bit           kat_en;
   logic [7:0]   sbox_t[256];
   bit           hold_prev = 1'b0;
   logic [127:0] ct_prev;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s (bound expired or unexpected event)", name);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   task automatic build_sbox;
      logic [7:0] inv;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (v != 0 && gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k,
                                            output logic [127:0] r1);
      logic [7:0]   s[16], t[16], a[4];
      logic [31:0]  w[4], tw;
      logic [7:0]   rc;
      logic [127:0] res;
      rc = 8'h01;
      r1 = '0;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
      for (int j = 0; j < 4; j++) w[j] = k[127-32*j -: 32];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int rr = 0; rr < 4; rr++) a[rr] = s[4*c+rr];
               s[4*c]   = gmul(8'h02, a[0]) ^ gmul(8'h03, a[1]) ^ a[2] ^ a[3];
               s[4*c+1] = a[0] ^ gmul(8'h02, a[1]) ^ gmul(8'h03, a[2]) ^ a[3];
               s[4*c+2] = a[0] ^ a[1] ^ gmul(8'h02, a[2]) ^ gmul(8'h03, a[3]);
               s[4*c+3] = gmul(8'h03, a[0]) ^ a[1] ^ a[2] ^ gmul(8'h02, a[3]);
            end
         end
         tw = {sbox_t[w[3][23:16]], sbox_t[w[3][15:8]], sbox_t[w[3][7:0]], sbox_t[w[3][31:24]]}
              ^ {rc, 24'h000000};
         w[0] ^= tw;
         w[1] ^= w[0];
         w[2] ^= w[1];
         w[3] ^= w[2];
         rc = xt(rc);
         for (int i = 0; i < 16; i++) s[i] ^= w[i/4][31-8*(i%4) -: 8];
         if (r == 1) for (int i = 0; i < 16; i++) r1[127-8*i -: 8] = s[i];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // ---------------- input monitor: push expected on acceptance ----------------
   always @(negedge clk) begin : imon
      exp_t         e;
      logic [127:0] r1;
      if (!rst && in_valid && in_ready) begin
         e.ct      = aes_ref(plaintext, key, r1);
         e.kat     = kat;
         e.has_kat = kat_en;
         e.acc     = cyc;
         exp_q.push_back(e);
      end
   end

   // ---------------- output monitor ----------------
   always @(negedge clk) begin : omon
      exp_t e;
      if (rst) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         chk("excl_ready_busy", in_ready & busy, 1'b0);
         chk("excl_ready_valid", in_ready & out_valid, 1'b0);
         if (out_valid) begin
            if (hold_prev) chk("ct_stable", ciphertext, ct_prev);
            else if (exp_q.size() == 0) fail("unexpected_out_valid");
            else chk("latency", 128'(cyc), 128'(exp_q[0].acc + 11));
            if (out_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("ct_model", ciphertext, e.ct);
               if (e.has_kat) chk("ct_kat", ciphertext, e.kat);
            end
         end
         hold_prev = out_valid && !out_ready;
         ct_prev   = ciphertext;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step;
      @(posedge clk);
      #1;
      if (rand_or) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_accept(input bit drop);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         step();
         @(negedge clk);
         n++;
      end
      if (!in_ready) fail("accept_timeout");
      step();
      if (drop) in_valid = 1'b0;
   endtask

   task automatic send(input logic [127:0] p, input logic [127:0] k, input logic [127:0] kv,
                       input bit hk, input bit drop);
      plaintext = p;
      key       = k;
      kat       = kv;
      kat_en    = hk;
      in_valid  = 1'b1;
      wait_accept(drop);
   endtask

   task automatic wait_idle;
      int n;
      n = 0;
      @(negedge clk);
      while (!(in_ready && exp_q.size() == 0) && n < 300) begin
         step();
         @(negedge clk);
         n++;
      end
      if (n >= 300) fail("idle_timeout");
      step();
   endtask

   task automatic wait_out_valid;
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) fail("out_valid_timeout");
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_reset_state(input string tag);
      @(negedge clk);
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_ct"}, ciphertext, 128'h0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      plaintext = '0;
      key       = '0;
      kat       = '0;
      kat_en    = 1'b0;
      build_sbox();
      step();
      step();
      rst = 1'b0;
      check_reset_state("reset");
      step();

      // FIPS-197 C.1 with a ready sink.
      out_ready = 1'b1;
      send(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b1);
      wait_idle();

      // FIPS-197 App. B, with the state after round 1 inspected.
      send(B_PT, B_KEY, B_CT, 1'b1, 1'b1);
      step();
      chk("round1_state", dut.r_st, B_R1);
      wait_idle();

      // Backpressure: hold the result for several cycles.
      out_ready = 1'b0;
      send(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b1);
      wait_out_valid();
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
      end
      step();
      out_ready = 1'b1;
      step();
      @(negedge clk);
      chk("bp_release_in_ready", in_ready, 1'b1);
      chk("bp_release_out_valid", out_valid, 1'b0);
      step();

      // Traffic on the input while a block is in flight must be ignored.
      send(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b1);
      repeat (10) begin
         in_valid  = 1'($urandom_range(0, 1));
         plaintext = rnd128();
         key       = rnd128();
         @(negedge clk);
         chk("busy_in_ready", in_ready, 1'b0);
         step();
      end
      in_valid = 1'b0;
      wait_idle();

      // Reset in the middle of the rounds discards the block.
      send(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b1);
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_state("midreset");
      step();
      send(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b1);
      wait_idle();

      // Back-to-back with in_valid held high.
      send(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b0);
      plaintext = B_PT;
      key       = B_KEY;
      kat       = B_CT;
      kat_en    = 1'b1;
      wait_out_valid();
      step();
      @(negedge clk);
      chk("b2b_in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_busy", busy, 1'b1);
      wait_idle();

      // Random blocks with a randomly stalling sink.
      rand_or = 1'b1;
      for (int j = 0; j < 20; j++) begin
         send(rnd128(), rnd128(), '0, 1'b0, 1'b1);
         repeat ($urandom_range(0, 3)) step();
      end
      wait_idle();
      rand_or   = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog (simulation time limit reached)");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/aes128_encrypt_ctrl.md
# aes128_encrypt_ctrl

Iterative AES-128 encryption controller that sequences one cipher round per clock around the existing `mixcolumns` datapath block. It holds the round state and the on-the-fly round key, applies SubBytes/ShiftRows/MixColumns/AddRoundKey per round, skips MixColumns in round 10, and presents the ciphertext on a valid/ready output. It sits between the host-side block interface and the top-level engine wrapper.

## Interface
- Parameters: none.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  plaintext and key present.
- `in_ready`  out  1  controller can accept a block; high only in IDLE.
- `plaintext`  in  128  input block, FIPS-197 byte order (byte 0 = [127:120]).
- `key`  in  128  cipher key, FIPS-197 byte order.
- `out_valid`  out  1  `ciphertext` valid; held until taken.
- `out_ready`  in  1  downstream accepts ciphertext.
- `ciphertext`  out  128  result, FIPS-197 byte order.
- `busy`  out  1  high in ROUND and FINAL.

## Operation
- States: IDLE, ROUND, FINAL, HOLD.
- IDLE: `in_ready`=1. On `in_valid`: `st <= plaintext ^ key`, `rk <= key`, `rnd <= 1`, go ROUND. `plaintext`/`key` sampled only at this edge; later changes ignored.
- ROUND (rnd 1..9): `nk = expand(rk, rcon[rnd])`; `st <= MC(SR(SB(st))) ^ nk`; `rk <= nk`; `rnd <= rnd+1`; after rnd 9 go FINAL.
- FINAL (rnd 10): `st <= SR(SB(st)) ^ expand(rk, rcon[10])`; go HOLD.
- HOLD: `out_valid`=1, `ciphertext`=`st`. On `out_ready` go IDLE; `ciphertext` stays stable while `out_valid`=1.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (4-bit `rnd`, values 0..10 only).
- Key expansion with words w0..w3 = rk[127:96]..rk[31:0]: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- SB: 16 state S-box lookups + 4 for SubWord, combinational inside the block. SR: row r rotated left by r columns.
- `mixcolumns` word mapping: FIPS column c (bits [127-32c -: 32]) drives `mixcolumns` state word c (bits [32c+31 -: 32]); row 0 is the MSB byte of each word. The output is remapped identically. Bench checks this mapping via known-answer vectors.
- `mixcolumns` is combinational; its `clk` input is tied to `clk` and unused.
- No pipelining: one block in flight. `in_valid` outside IDLE is ignored (no buffering).

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `busy`=0, `ciphertext`=0, internal `st`/`rk`=0, `rnd`=0.
- Acceptance edge E0; ROUND on edges E1..E9, FINAL on E10; `out_valid` visible in cycle after E10 (10-cycle latency from acceptance).
- `out_valid`&`out_ready` at edge Ex: IDLE after Ex, `in_ready`=1 cycle after Ex; next acceptance earliest Ex+1. Minimum period 12 cycles/block.
- `out_ready` asserted while `out_valid`=0: no effect.
- `rst` at any state (including mid-round or HOLD): next cycle IDLE with all reset values; partial result discarded, `out_valid` never pulses for it.
- `rst` and `in_valid` same edge: reset wins; block not accepted.
- `busy` = (state == ROUND or FINAL); `in_ready` and `busy` never both 1; `in_ready` and `out_valid` never both 1.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, `out_ready`=1 -> `out_valid` 10 cycles after acceptance, ct 69c4e0d86a7b0430d8cdb78070b4c55a, one-cycle `out_valid`.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32; also check `st` after round 1 = a49c7ff2689f352b6b5bea43026a5049 (FIPS ordering).
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` -> `out_valid` and `ciphertext` stable 5 cycles, `in_ready`=0; raise `out_ready` -> IDLE next cycle.
- Busy-time input: toggle `in_valid` with different pt/key during E1..E10 -> ignored, C.1 result unchanged, `in_ready`=0 throughout.
- Reset mid-operation: assert `rst` one cycle at round 5 -> next cycle `in_ready`=1, `out_valid`=0, `busy`=0; then C.1 job yields correct ct.
- Back-to-back: two jobs (C.1 then App. B) with `in_valid` held high -> second accepted exactly one cycle after first handshake; both ciphertexts correct, in order.
